// File: rtl/frame_mem_arbiter.sv
// rtl/frame_mem_arbiter.sv - single-port frame memory arbiter: VGA read > fill engine > host write
module frame_mem_arbiter #(
    parameter int COLS    = 64,
    parameter int ROWS    = 48,
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int ADDR_W  = 12,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_req,
    input  logic [X_W-1:0]     rd_x,
    input  logic [Y_W-1:0]     rd_y,
    output logic               rd_valid,
    output logic [COLOR_W-1:0] rd_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [X_W-1:0]     wr_x,
    input  logic [Y_W-1:0]     wr_y,
    input  logic [COLOR_W-1:0] wr_color,
    output logic               wr_drop,
    input  logic               fill_start,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               fill_busy,
    output logic               fill_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    fill_cnt_q;
    logic [COLOR_W-1:0]   fill_color_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 rd_valid_q;
    logic                 rd_oob_q;
    logic [COLOR_W-1:0]   rd_hold_q;
    logic                 drop_q;

    logic                 rd_oob;
    logic                 wr_oob;
    logic                 fill_grant;
    logic [COLOR_W-1:0]   rd_data_d;

    assign rd_oob = (32'(rd_y) >= 32'(ROWS));
    assign wr_oob = (32'(wr_y) >= 32'(ROWS));

    // Grant decode; mem_addr parks on the last driven address when nothing owns the port.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = '0;
        wr_ready   = 1'b0;
        fill_done  = 1'b0;
        fill_grant = 1'b0;
        if (rst) begin
            mem_addr = '0;
        end else if (rd_req) begin
            if (!rd_oob) begin
                mem_addr = {rd_y, rd_x};
            end
        end else if (state_q == FILL) begin
            mem_we     = 1'b1;
            mem_addr   = fill_cnt_q;
            mem_wdata  = fill_color_q;
            fill_grant = 1'b1;
            fill_done  = (fill_cnt_q == LAST_CELL);
        end else begin
            wr_ready = 1'b1;
            if (wr_valid && !wr_oob) begin
                mem_we    = 1'b1;
                mem_addr  = {wr_y, wr_x};
                mem_wdata = wr_color;
            end
        end
    end

    assign rd_data_d = rd_oob_q ? '0 : mem_rdata;
    assign rd_data   = rd_valid_q ? rd_data_d : rd_hold_q;
    assign rd_valid  = rd_valid_q;
    assign wr_drop   = drop_q;
    assign fill_busy = (state_q == FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fill_cnt_q   <= '0;
            fill_color_q <= '0;
            addr_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
            rd_hold_q    <= '0;
            drop_q       <= 1'b0;
        end else begin
            addr_q     <= mem_addr;
            rd_valid_q <= rd_req;
            rd_oob_q   <= rd_oob;
            drop_q     <= wr_ready && wr_valid && wr_oob;
            if (rd_valid_q) begin
                rd_hold_q <= rd_data_d;
            end
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        state_q      <= FILL;
                        fill_cnt_q   <= '0;
                        fill_color_q <= fill_color;
                    end
                end
                FILL: begin
                    if (fill_grant) begin
                        if (fill_done) begin
                            state_q    <= IDLE;
                            fill_cnt_q <= '0;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb/tb_frame_mem_arbiter.sv - directed scoreboard bench for frame_mem_arbiter
module tb_frame_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [5:0]  rd_x, rd_y;
    logic        rd_valid;
    logic [2:0]  rd_data;
    logic        wr_valid, wr_ready;
    logic [5:0]  wr_x, wr_y;
    logic [2:0]  wr_color;
    logic        wr_drop;
    logic        fill_start;
    logic [2:0]  fill_color;
    logic        fill_busy, fill_done;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;

    frame_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .wr_drop(wr_drop),
        .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
        .fill_done(fill_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // External frame memory: registered read, write-first not required.
    logic [2:0] mem_model [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        mem_rdata <= mem_model[mem_addr];
    end

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    logic [2:0] exp_q[$];
    logic [2:0] ref_mem [0:3071];
    logic [2:0] sb_e;
    int fill_wr_n = 0;
    int fill_done_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("rd_data", {29'd0, rd_data}, {29'd0, sb_e});
            end
        end
        if (rst === 1'b0 && mem_we === 1'b1 && fill_busy === 1'b1) fill_wr_n++;
        if (rst === 1'b0 && fill_done === 1'b1) fill_done_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int x, input int y);
        int a;
        a = y * 64 + x;
        rd_req = 1'b1;
        rd_x = x[5:0];
        rd_y = y[5:0];
        if (y < 48) exp_q.push_back(ref_mem[a]);
        else exp_q.push_back(3'd0);
    endtask

    initial begin
        int mcnt, nrd, a, x, y;
        logic rd;
        for (int i = 0; i < 4096; i++) mem_model[i] = (i >= 3072) ? 3'd7 : 3'd0;
        for (int i = 0; i < 3072; i++) ref_mem[i] = 3'd0;
        rst = 1'b1; rd_req = 1'b0; rd_x = '0; rd_y = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
        fill_start = 1'b0; fill_color = '0;
        repeat (2) tick();

        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_fill_busy", fill_busy, 0);
        chk("rst_fill_done", fill_done, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", wr_ready, 1);
        chk("post_rst_mem_we", mem_we, 0);
        tick();

        // Host write then read back
        wr_valid = 1'b1; wr_x = 6'd5; wr_y = 6'd2; wr_color = 3'd6;
        @(negedge clk);
        chk("wr_addr", mem_addr, 12'h085);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 6);
        tick();
        ref_mem[12'h085] = 3'd6;
        wr_valid = 1'b0;
        do_read(5, 2);
        @(negedge clk);
        chk("rd_grant_addr", mem_addr, 12'h085);
        chk("rd_grant_we", mem_we, 0);
        chk("rd_grant_wr_ready", wr_ready, 0);
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_latency_valid", rd_valid, 1);
        tick();
        @(negedge clk);
        chk("rd_valid_low", rd_valid, 0);
        chk("rd_data_hold", rd_data, 6);
        tick();

        // Reads block a pending host write for three cycles
        wr_valid = 1'b1; wr_x = 6'd10; wr_y = 6'd3; wr_color = 3'd5;
        for (int k = 0; k < 3; k++) begin
            do_read(5, 2);
            @(negedge clk);
            chk("blk_wr_ready", wr_ready, 0);
            chk("blk_mem_we", mem_we, 0);
            tick();
        end
        rd_req = 1'b0;
        @(negedge clk);
        chk("unblk_we", mem_we, 1);
        chk("unblk_addr", mem_addr, 12'h0CA);
        chk("unblk_wdata", mem_wdata, 5);
        tick();
        ref_mem[12'h0CA] = 3'd5;
        wr_x = 6'd63; wr_y = 6'd47; wr_color = 3'd7;
        @(negedge clk);
        chk("corner_wr_addr", mem_addr, 12'hBFF);
        tick();
        ref_mem[12'hBFF] = 3'd7;
        wr_valid = 1'b0;
        do_read(10, 3);
        @(negedge clk);
        tick();
        rd_req = 1'b0;

        // Out-of-range host write
        wr_valid = 1'b1; wr_x = 6'd1; wr_y = 6'd50; wr_color = 3'd2;
        @(negedge clk);
        chk("oob_wr_we", mem_we, 0);
        chk("oob_wr_ready", wr_ready, 1);
        chk("oob_addr_hold", mem_addr, 12'h0CA);
        chk("oob_drop_same", wr_drop, 0);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("oob_drop_pulse", wr_drop, 1);
        tick();
        @(negedge clk);
        chk("oob_drop_clear", wr_drop, 0);
        tick();
        do_read(63, 47);
        @(negedge clk);
        chk("corner_rd_addr", mem_addr, 12'hBFF);
        chk("corner_rd_we", mem_we, 0);
        tick();
        do_read(0, 60);
        @(negedge clk);
        chk("oob_rd_we", mem_we, 0);
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        tick();

        // Whole-frame fill with interleaved reads and an ignored restart
        fill_wr_n = 0; fill_done_n = 0;
        fill_start = 1'b1; fill_color = 3'd3;
        @(negedge clk);
        chk("fill_busy_before", fill_busy, 0);
        tick();
        fill_start = 1'b0; fill_color = 3'd0;
        mcnt = 0; nrd = 0;
        for (int cyc = 0; cyc < 5000 && mcnt < 3072; cyc++) begin
            rd = ((cyc % 30) == 7) && (nrd < 100);
            if (rd) begin
                y = int'($urandom_range(0, 47));
                x = int'($urandom_range(0, 63));
                a = y * 64 + x;
                rd_req = 1'b1; rd_x = x[5:0]; rd_y = y[5:0];
                exp_q.push_back((a < mcnt) ? 3'd3 : ref_mem[a]);
                nrd++;
            end else begin
                rd_req = 1'b0;
            end
            fill_start = (cyc == 1500);
            fill_color = (cyc == 1500) ? 3'd5 : 3'd0;
            @(negedge clk);
            chk("fill_busy", fill_busy, 1);
            chk("fill_wr_ready", wr_ready, 0);
            chk("fill_done", fill_done, (!rd && mcnt == 3071) ? 1 : 0);
            if (rd) begin
                chk("fill_stall_we", mem_we, 0);
            end else begin
                chk("fill_we", mem_we, 1);
                chk("fill_addr", mem_addr, mcnt);
                chk("fill_wdata", mem_wdata, 3);
                mcnt++;
            end
            tick();
        end
        rd_req = 1'b0; fill_start = 1'b0;
        for (int i = 0; i < 3072; i++) ref_mem[i] = 3'd3;
        @(negedge clk);
        chk("fill_busy_after", fill_busy, 0);
        chk("fill_write_count", fill_wr_n, 3072);
        chk("fill_done_count", fill_done_n, 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            do_read(int'($urandom_range(0, 63)), int'($urandom_range(0, 47)));
            @(negedge clk);
            tick();
        end
        rd_req = 1'b0;

        // Reset aborts a fill at fill_cnt=1000
        fill_start = 1'b1; fill_color = 3'd2;
        @(negedge clk);
        tick();
        fill_start = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (n == 0 || n == 999) chk("fill2_addr", mem_addr, n);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rstm_we", mem_we, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstm_busy", fill_busy, 0);
        chk("rstm_we_after", mem_we, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstm_idle_we", mem_we, 0);
            tick();
        end
        for (int i = 0; i < 1000; i++) ref_mem[i] = 3'd2;
        do_read(39, 15);
        @(negedge clk);
        tick();
        do_read(40, 15);
        @(negedge clk);
        tick();
        rd_req = 1'b0;

        // Host write and fill_start together: write first, fill from address 0 next
        wr_valid = 1'b1; wr_x = 6'd1; wr_y = 6'd1; wr_color = 3'd6;
        fill_start = 1'b1; fill_color = 3'd4;
        @(negedge clk);
        chk("sim_we", mem_we, 1);
        chk("sim_addr", mem_addr, 12'h041);
        chk("sim_wdata", mem_wdata, 6);
        chk("sim_busy", fill_busy, 0);
        tick();
        wr_valid = 1'b0; fill_start = 1'b0; fill_color = 3'd0;
        @(negedge clk);
        chk("restart_busy", fill_busy, 1);
        chk("restart_addr0", mem_addr, 0);
        chk("restart_wdata", mem_wdata, 4);
        tick();
        @(negedge clk);
        chk("restart_addr1", mem_addr, 1);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
